// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // Operation codes match the RISC-V M-extension funct3 encoding.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient.
  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    Result;

  // Pipeline side: issues operations and consumes results.
  modport master (
    output flush, in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, Result
  );

  // Unit side.
  modport slave (
    input  flush, in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/muldiv_special.sv
// Combinational detection of divide-by-zero, signed overflow and zero operands,
// together with the architecturally fixed result for each case.
module muldiv_special
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  muldiv_op_e            i_op,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  output logic                  o_hit,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic w_a_zero, w_b_zero, w_ovf;

  assign w_a_zero = (i_src_a == '0);
  assign w_b_zero = (i_src_b == '0);
  assign w_ovf    = is_signed_a(i_op) && is_div(i_op) && (i_src_a == MIN_INT) && (i_src_b == '1);

  // Priority: divide-by-zero, then overflow, then a zero operand.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    o_hit    = 1'b0;
    o_result = '0;
    if (is_div(i_op)) begin
      if (w_b_zero) begin
        o_hit    = 1'b1;
        o_result = is_rem(i_op) ? i_src_a : '1;
      end else if (w_ovf) begin
        o_hit    = 1'b1;
        o_result = is_rem(i_op) ? '0 : MIN_INT;
      end else if (w_a_zero) begin
        o_hit    = 1'b1;
      end
    end else if (w_a_zero || w_b_zero) begin
      o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, valid/ready on both sides.
// Optional early-out for special operands: define MULDIV_FAST_SPECIAL_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  muldiv_state_e  r_state;
  logic [CW-1:0]  r_count;
  muldiv_op_e     r_op;
  logic           r_neg;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;      // MUL: {partial hi, multiplier}; DIV: low half dividend -> quotient
  logic [W:0]     r_rem;
  logic           r_spec_hit;
  logic [W-1:0]   r_spec_res;
  logic [W-1:0]   r_result;
  logic           r_out_valid;

  muldiv_op_e     w_op;
  logic           w_sign_a, w_sign_b, w_neg, w_in_ready;
  logic [W-1:0]   w_abs_a, w_abs_b;
  logic [W:0]     w_sum, w_shift, w_diff;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_q_fix, w_r_fix, w_fix;
  logic           w_spec_hit;
  logic [W-1:0]   w_spec_res;

  assign w_op       = muldiv_op_e'(bus.Operation[2:0]);
  assign w_in_ready = (r_state == IDLE) && !bus.flush;
  assign w_sign_a   = is_signed_a(w_op) & bus.SrcA[W-1];
  assign w_sign_b   = is_signed_b(w_op) & bus.SrcB[W-1];
  assign w_abs_a    = w_sign_a ? -bus.SrcA : bus.SrcA;
  assign w_abs_b    = w_sign_b ? -bus.SrcB : bus.SrcB;
  // Remainder follows the dividend; products and quotients follow signA^signB.
  assign w_neg      = is_rem(w_op) ? w_sign_a : (w_sign_a ^ w_sign_b);

  // One shift-add step: add multiplicand when the current multiplier bit is set.
  assign w_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);
  // One restoring step: bring in the next dividend bit and trial-subtract.
  assign w_shift = {r_rem[W-1:0], r_acc[W-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  assign w_prod_fix = r_neg ? -r_acc : r_acc;
  assign w_q_fix    = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_r_fix    = r_neg ? -r_rem[W-1:0] : r_rem[W-1:0];

  // Select the architectural result half / quotient / remainder.
  always_comb begin
    w_fix = w_prod_fix[W-1:0];
    case (r_op)
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              w_fix = w_q_fix;
      OP_REM, OP_REMU:              w_fix = w_r_fix;
      default:                      w_fix = w_prod_fix[W-1:0];
    endcase
  end

  muldiv_special #(.DATA_WIDTH(W)) u_special (
    .i_op     (w_op),
    .i_src_a  (bus.SrcA),
    .i_src_b  (bus.SrcB),
    .o_hit    (w_spec_hit),
    .o_result (w_spec_res)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Result    = r_result;

  // Control FSM and datapath; flush aborts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so a reset mid-operation leaves no stale state.
      r_state     <= IDLE;
      r_count     <= '0;
      r_op        <= OP_MUL;
      r_neg       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_spec_hit  <= 1'b0;
      r_spec_res  <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_op       <= w_op;
            r_neg      <= w_neg;
            r_a        <= w_abs_a;
            r_b        <= w_abs_b;
            r_acc      <= is_div(w_op) ? {{W{1'b0}}, w_abs_a} : {{W{1'b0}}, w_abs_b};
            r_rem      <= '0;
            r_count    <= '0;
            r_spec_hit <= w_spec_hit;
            r_spec_res <= w_spec_res;
`ifdef MULDIV_FAST_SPECIAL_EN
            if (w_spec_hit) begin
              r_result    <= w_spec_res;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end
        end
        BUSY: begin
          // Steps run on counts 0..W-1; the terminal count hands over to FIX.
          if (r_count == CW'(W)) begin
            r_state <= FIX;
          end else begin
            r_count <= r_count + 1'b1;
            if (is_div(r_op)) begin
              r_rem <= w_diff[W] ? w_shift : w_diff;
              r_acc <= {r_acc[2*W-1:W], r_acc[W-2:0], ~w_diff[W]};
            end else begin
              r_acc <= {w_sum, r_acc[W-1:1]};
            end
          end
        end
        FIX: begin
          r_result    <= r_spec_hit ? r_spec_res : w_fix;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
